// File: rtl/traffic_pkg.sv
// Phase codes, lamp encodings and decode helpers shared by the traffic phase controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } phase_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // A pedestrian request never leaves more than this many green seconds.
  localparam logic [6:0] PED_LIMIT = 7'd5;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } lights_t;

  function automatic lights_t decode_lights(input phase_t p);
    lights_t l;
    case (p)
      NS_GREEN:  l = '{ns: LT_GRN, ew: LT_RED};
      NS_YELLOW: l = '{ns: LT_YEL, ew: LT_RED};
      EW_GREEN:  l = '{ns: LT_RED, ew: LT_GRN};
      EW_YELLOW: l = '{ns: LT_RED, ew: LT_YEL};
      default:   l = '{ns: LT_RED, ew: LT_RED};
    endcase
    return l;
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALL_RED_A;
      ALL_RED_A: n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALL_RED_B;
      default:   n = NS_GREEN;
    endcase
    return n;
  endfunction

  function automatic logic is_green(input phase_t p);
    return (p == NS_GREEN) || (p == EW_GREEN);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an active-low raw button followed by a falling-edge
// detector; a press of any length yields one single-cycle pulse.
module btn_edge (
  input  logic clk_16,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  // sync[0..1] are the synchronizer, sync[2] holds the previous synchronized level.
  logic [2:0] sync;

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], btn};
    end
  end

  assign press = sync[2] & ~sync[1];

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-way traffic light phase sequencer with per-second countdown, pause and
// adjustable green length. Optional pedestrian shortening: define PED_REQ_EN.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 16_000_000,
  parameter int GREEN_DEF  = 20,
  parameter int GREEN_MIN  = 5,
  parameter int GREEN_MAX  = 60,
  parameter int YELLOW_LEN = 3,
  parameter int ALLRED_LEN = 1
) (
  input  logic       clk_16,
  input  logic       rst_n,
  input  logic       pause,
  input  logic       btn_up,
  input  logic       btn_dn,
`ifdef PED_REQ_EN
  input  logic       ped_req,
`endif
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic [2:0] phase,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic [6:0] green_len
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [6:0] G_DEF  = 7'(GREEN_DEF);
  localparam logic [6:0] G_MIN  = 7'(GREEN_MIN);
  localparam logic [6:0] G_MAX  = 7'(GREEN_MAX);
  localparam logic [6:0] Y_LEN  = 7'(YELLOW_LEN);
  localparam logic [6:0] AR_LEN = 7'(ALLRED_LEN);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  phase_t        state;
  phase_t        state_next;
  logic [6:0]    remain;
  logic [6:0]    remain_next;
  logic [6:0]    load_len;
  lights_t       lights_next;
  logic          up_press;
  logic          dn_press;

  btn_edge u_btn_up (
    .clk_16 (clk_16),
    .rst_n  (rst_n),
    .btn    (btn_up),
    .press  (up_press)
  );

  btn_edge u_btn_dn (
    .clk_16 (clk_16),
    .rst_n  (rst_n),
    .btn    (btn_dn),
    .press  (dn_press)
  );

`ifdef PED_REQ_EN
  logic ped_press;
  logic ped_pend;
  logic ped_pend_next;

  btn_edge u_btn_ped (
    .clk_16 (clk_16),
    .rst_n  (rst_n),
    .btn    (ped_req),
    .press  (ped_press)
  );

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend <= 1'b0;
    end else begin
      ped_pend <= ped_pend_next;
    end
  end
`endif

  // Pausing freezes the count mid-second so resuming neither loses nor repeats a tick.
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (pause) begin
      tick_cnt <= tick_cnt;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = ~pause & (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      green_len <= G_DEF;
    end else begin
      case ({up_press, dn_press})
        2'b10: begin
          if (green_len < G_MAX) begin
            green_len <= green_len + 7'd1;
          end
        end
        2'b01: begin
          if (green_len > G_MIN) begin
            green_len <= green_len - 7'd1;
          end
        end
        default: green_len <= green_len;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    remain_next = remain;
    load_len    = green_len;
`ifdef PED_REQ_EN
    ped_pend_next = ped_pend | (ped_press & ~is_green(state));
`endif
    case (state)
      NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B: begin
        if (tick && (remain <= 7'd1)) begin
          state_next = next_phase(state);
          case (state_next)
            NS_YELLOW, EW_YELLOW: load_len = Y_LEN;
            ALL_RED_A, ALL_RED_B: load_len = AR_LEN;
            default:              load_len = green_len;
          endcase
`ifdef PED_REQ_EN
          if (is_green(state_next) && ped_pend_next) begin
            if (load_len > PED_LIMIT) begin
              load_len = PED_LIMIT;
            end else begin
              load_len = load_len;
            end
            ped_pend_next = 1'b0;
          end else begin
            ped_pend_next = ped_pend_next;
          end
`endif
          remain_next = load_len;
        end else if (tick) begin
          remain_next = remain - 7'd1;
        end else begin
          remain_next = remain;
        end
`ifdef PED_REQ_EN
        // A green already running is cut short directly rather than latched.
        if (ped_press && is_green(state) && (remain > PED_LIMIT)) begin
          remain_next = PED_LIMIT;
        end else begin
          remain_next = remain_next;
        end
`endif
      end
      default: begin
        state_next  = NS_GREEN;
        remain_next = green_len;
      end
    endcase
  end

  assign lights_next = decode_lights(state_next);

  // Lamps decode the next phase so they change on the same edge as the phase register.
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NS_GREEN;
      remain   <= G_DEF;
      light_ns <= LT_GRN;
      light_ew <= LT_RED;
    end else begin
      state    <= state_next;
      remain   <= remain_next;
      light_ns <= lights_next.ns;
      light_ew <= lights_next.ew;
    end
  end

  assign phase    = state;
  assign cnt_tens = 4'(remain / 7'd10);
  assign cnt_ones = 4'(remain % 7'd10);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl with TICK_DIV = 4: a cycle-indexed
// scoreboard of expected phase/remain values plus per-scenario inline checks.
module tb_traffic_phase_ctrl;

  logic       clk_16;
  logic       rst_n;
  logic       pause;
  logic       btn_up;
  logic       btn_dn;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic [2:0] phase;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic [6:0] green_len;
`ifdef PED_REQ_EN
  logic       ped_req;
`endif

  traffic_phase_ctrl #(
    .TICK_DIV   (4),
    .GREEN_DEF  (20),
    .GREEN_MIN  (5),
    .GREEN_MAX  (60),
    .YELLOW_LEN (3),
    .ALLRED_LEN (1)
  ) dut (
    .clk_16    (clk_16),
    .rst_n     (rst_n),
    .pause     (pause),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
`ifdef PED_REQ_EN
    .ped_req   (ped_req),
`endif
    .light_ns  (light_ns),
    .light_ew  (light_ew),
    .phase     (phase),
    .cnt_tens  (cnt_tens),
    .cnt_ones  (cnt_ones),
    .green_len (green_len)
  );

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    logic [6:0] rem;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   m_cyc;
  int   m_phase;
  int   m_remain;
  int   m_glen;

  logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  initial clk_16 = 1'b0;
  always #5 clk_16 = ~clk_16;

  always @(posedge clk_16) cyc <= cyc + 1;

  // Scoreboard: each entry must match exactly on the negedge of its cycle.
  always @(negedge clk_16) begin
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      tests++;
      if (mon_e.cyc != cyc || phase !== mon_e.ph ||
          cnt_tens !== 4'(mon_e.rem / 7'd10) || cnt_ones !== 4'(mon_e.rem % 7'd10) ||
          light_ns !== ns_tab[mon_e.ph] || light_ew !== ew_tab[mon_e.ph]) begin
        fails++;
        $display("FAIL countdown cyc %0d (want cyc %0d): got phase %0d cnt %0d%0d ns %b ew %b, want phase %0d remain %0d ns %b ew %b",
                 cyc, mon_e.cyc, phase, cnt_tens, cnt_ones, light_ns, light_ew,
                 mon_e.ph, mon_e.rem, ns_tab[mon_e.ph], ew_tab[mon_e.ph]);
      end
    end
  end

  function automatic int dur(input int p);
    if (p == 0 || p == 3) return m_glen;
    if (p == 1 || p == 4) return 3;
    return 1;
  endfunction

  // Expect one value just before each tick (no early decrement) and one right after.
  task automatic push_ticks(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = m_cyc + 3; e.ph = 3'(m_phase); e.rem = 7'(m_remain);
      q.push_back(e);
      m_cyc += 4;
      if (m_remain > 1) begin
        m_remain--;
      end else begin
        m_phase  = (m_phase == 5) ? 0 : m_phase + 1;
        m_remain = dur(m_phase);
      end
      e.cyc = m_cyc; e.ph = 3'(m_phase); e.rem = 7'(m_remain);
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pause = 1'b0; btn_up = 1'b1; btn_dn = 1'b1;
`ifdef PED_REQ_EN
    ped_req = 1'b1;
`endif
    q.delete();
    repeat (3) @(negedge clk_16);
    rst_n = 1'b1;
    m_cyc = cyc; m_phase = 0; m_remain = 20; m_glen = 20;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up = ~up; btn_dn = ~dn;
    repeat (4) @(negedge clk_16);
    btn_up = 1'b1; btn_dn = 1'b1;
    repeat (4) @(negedge clk_16);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (phase !== 3'd0 || cnt_tens !== 4'd2 || cnt_ones !== 4'd0 || green_len !== 7'd20 ||
        light_ns !== 3'b001 || light_ew !== 3'b100) begin
      fails++;
      $display("FAIL reset: got phase %0d cnt %0d%0d glen %0d ns %b ew %b, want 0 20 20 001 100",
               phase, cnt_tens, cnt_ones, green_len, light_ns, light_ew);
    end
  endtask

  task automatic test_countdown();
    push_ticks(20);
    for (int i = 0; i < 1000 && q.size() > 0; i++) @(negedge clk_16);
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL countdown drain: %0d entries left, want 0", q.size()); q.delete();
    end
  endtask

  task automatic test_full_cycle();
    push_ticks(28);
    for (int i = 0; i < 1000 && q.size() > 0; i++) @(negedge clk_16);
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL full_cycle drain: %0d entries left, want 0", q.size()); q.delete();
    end
  endtask

  task automatic test_pause();
    int c;
    push_ticks(8);
    for (int i = 0; i < 1000 && q.size() > 0; i++) @(negedge clk_16);
    while (cyc < m_cyc + 2) @(negedge clk_16);
    pause = 1'b1;
    while (cyc < m_cyc + 52) @(negedge clk_16);
    tests++;
    if (phase !== 3'd0 || cnt_tens !== 4'd1 || cnt_ones !== 4'd2 || dut.tick_cnt !== 2'd2) begin
      fails++;
      $display("FAIL pause_hold: got phase %0d cnt %0d%0d tick_cnt %0d, want 0 12 2",
               phase, cnt_tens, cnt_ones, dut.tick_cnt);
    end
    c = cyc;
    pause = 1'b0;
    m_cyc = c - 2;
    push_ticks(1);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk_16);
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL pause_resume drain: %0d entries left, want 0", q.size()); q.delete();
    end
  endtask

  task automatic test_btn_up();
    m_glen = 23;
    push_ticks(16);
    btn_up = 1'b0;
    repeat (2) @(negedge clk_16);
    tests++;
    if (green_len !== 7'd20) begin
      fails++; $display("FAIL btn_latency_early: got %0d, want 20", green_len);
    end
    @(negedge clk_16);
    tests++;
    if (green_len !== 7'd21) begin
      fails++; $display("FAIL btn_latency: got %0d, want 21", green_len);
    end
    repeat (5) @(negedge clk_16);
    btn_up = 1'b1;
    repeat (4) @(negedge clk_16);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    tests++;
    if (green_len !== 7'd23) begin
      fails++; $display("FAIL btn_up_three: got %0d, want 23", green_len);
    end
    for (int i = 0; i < 1000 && q.size() > 0; i++) @(negedge clk_16);
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL btn_up drain: %0d entries left, want 0", q.size()); q.delete();
    end
  endtask

  task automatic test_btn_dn_sat();
    for (int i = 0; i < 20; i++) press(1'b0, 1'b1);
    tests++;
    if (green_len !== 7'd5) begin
      fails++; $display("FAIL btn_dn_sat: got %0d, want 5", green_len);
    end
    press(1'b1, 1'b1);
    tests++;
    if (green_len !== 7'd5) begin
      fails++; $display("FAIL btn_both_at_min: got %0d, want 5", green_len);
    end
    press(1'b1, 1'b0);
    tests++;
    if (green_len !== 7'd6) begin
      fails++; $display("FAIL btn_up_after_min: got %0d, want 6", green_len);
    end
    press(1'b1, 1'b1);
    tests++;
    if (green_len !== 7'd6) begin
      fails++; $display("FAIL btn_both: got %0d, want 6", green_len);
    end
    m_glen = 6;
  endtask

  task automatic test_illegal();
    @(negedge clk_16);
    dut.state = traffic_pkg::phase_t'(3'd7);
    @(negedge clk_16);
    tests++;
    if (phase !== 3'd0 || cnt_tens !== 4'(m_glen / 10) || cnt_ones !== 4'(m_glen % 10) ||
        light_ns !== 3'b001 || light_ew !== 3'b100) begin
      fails++;
      $display("FAIL illegal_recover: got phase %0d cnt %0d%0d ns %b ew %b, want 0 remain %0d 001 100",
               phase, cnt_tens, cnt_ones, light_ns, light_ew, m_glen);
    end
  endtask

  task automatic test_rst_mid_yellow();
    do_reset();
    push_ticks(20);
    for (int i = 0; i < 1000 && q.size() > 0; i++) @(negedge clk_16);
    repeat (2) @(negedge clk_16);
    tests++;
    if (phase !== 3'd1) begin
      fails++; $display("FAIL pre_rst_phase: got %0d, want 1", phase);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (phase !== 3'd0 || cnt_tens !== 4'd2 || cnt_ones !== 4'd0 || green_len !== 7'd20 ||
        light_ns !== 3'b001 || light_ew !== 3'b100) begin
      fails++;
      $display("FAIL async_reset: got phase %0d cnt %0d%0d glen %0d ns %b ew %b, want 0 20 20 001 100",
               phase, cnt_tens, cnt_ones, green_len, light_ns, light_ew);
    end
    @(negedge clk_16);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; pause = 1'b0; btn_up = 1'b1; btn_dn = 1'b1;
`ifdef PED_REQ_EN
    ped_req = 1'b1;
`endif
    test_reset();
    test_countdown();
    test_full_cycle();
    test_pause();
    test_btn_up();
    test_btn_dn_sat();
    test_illegal();
    test_rst_mid_yellow();
    repeat (2) @(negedge clk_16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Phase sequencer for the two-way traffic light. It cycles NS/EW green, yellow and all-red phases and owns the per-second countdown, which halts while paused. A user-adjustable green duration is driven by the count-up/count-down buttons. The BCD digits it exports feed the existing 7-segment decoders for HEX1/HEX0.

Parameters:
TICK_DIV, 16_000_000, clk_16 cycles per one-second tick (bench uses 4)
GREEN_DEF, 20, green duration after reset, seconds
GREEN_MIN, 5, lower saturation bound of green duration
GREEN_MAX, 60, upper saturation bound of green duration
YELLOW_LEN, 3, yellow phase duration, seconds
ALLRED_LEN, 1, all-red clearance duration, seconds

Ports:
clk_16  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
pause  in  1  switch; 1 freezes tick and countdown
btn_up  in  1  raw push button, active-low; press adds 1 s to green length
btn_dn  in  1  raw push button, active-low; press subtracts 1 s from green length
light_ns  out  3  {R,Y,G} one-hot for north-south
light_ew  out  3  {R,Y,G} one-hot for east-west
phase  out  3  current phase code
cnt_tens  out  4  BCD tens of remaining seconds
cnt_ones  out  4  BCD ones of remaining seconds
green_len  out  7  current programmed green duration, seconds

Behaviour:
- Reset values:
  - phase = NS_GREEN, remain = GREEN_DEF, green_len = GREEN_DEF, tick counter = 0.
  - light_ns = 3'b001, light_ew = 3'b100.
  - cnt_tens/cnt_ones = 2/0 for GREEN_DEF = 20.
- Tick counter (width ceil(log2(TICK_DIV))):
  - Increments each clk_16 cycle when pause = 0; holds when pause = 1.
  - On reaching TICK_DIV-1 it wraps to 0 and asserts the internal tick for that cycle.
- Phase sequence: NS_GREEN(0) -> NS_YELLOW(1) -> ALL_RED_A(2) -> EW_GREEN(3) -> EW_YELLOW(4) -> ALL_RED_B(5) -> NS_GREEN.
  - Codes 6 and 7 are illegal and recover to NS_GREEN with remain = green_len on the next cycle.
- On tick:
  - If remain > 1: remain decrements by 1.
  - If remain == 1: phase advances and remain loads the next phase's duration in the same cycle (green_len, YELLOW_LEN or ALLRED_LEN).
  - remain is never displayed as 0.
- Lights are registered decodes of phase, updating the cycle phase changes:
  - NS_GREEN: ns G, ew R.
  - NS_YELLOW: ns Y, ew R.
  - ALL_RED_A/B: both R.
  - EW_GREEN: ns R, ew G.
  - EW_YELLOW: ns R, ew Y.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a falling-edge detect giving a 1-cycle press pulse.
  - Press latency is 3 clk_16 cycles from the input edge to the green_len update.
  - up pulse: green_len += 1, saturating at GREEN_MAX.
  - dn pulse: green_len -= 1, saturating at GREEN_MIN.
  - Up and dn pulses in the same cycle: no change.
  - A held button produces exactly one pulse.
- green_len changes never modify a running phase. The new value applies at the next green load.
- Pause:
  - Freezes the tick counter, remain and phase.
  - Button adjustments remain active during pause.
  - On release, counting resumes from the frozen tick count; no tick is lost or duplicated.
- Display: remain is 7 bits, always 1..99; cnt_tens = remain/10 and cnt_ones = remain%10, combinational from registered remain.
- Asserting rst_n mid-phase restores all reset values immediately, independent of the clock.

Optional Feature:
PED_REQ_EN
- Defined:
  - Adds input ped_req (active-low raw button), synchronized and edge-detected like the count buttons.
  - A press during NS_GREEN or EW_GREEN with remain > 5 forces remain to 5 on the next cycle.
  - Presses during other phases are latched and applied at the next green entry, capping the loaded value at 5.
  - The latch clears when applied.
- Not defined: port absent, no shortening logic.

Decomposition:
- Package traffic_pkg:
  - phase codes NS_GREEN..ALL_RED_B;
  - light encodings LT_RED = 3'b100, LT_YEL = 3'b010, LT_GRN = 3'b001;
  - ped shortening limit constant 5.
- Sub-module btn_edge: 2-FF synchronizer plus falling-edge pulse. Instantiated for btn_up and btn_dn, and for ped_req under PED_REQ_EN.

Test Plan:
- Reset, TICK_DIV = 4, pause = 0, run 80 cycles -> remain 20 counts down to 1, then phase = 1 and remain = 3; light_ns = 010, light_ew = 100.
- Full cycle -> phase order 0,1,2,3,4,5,0; durations 20,3,1,20,3,1 s; both lights 100 during phases 2 and 5.
- Pause = 1 at remain = 12 for 50 cycles -> remain, phase and tick count unchanged; release -> next decrement exactly TICK_DIV minus the frozen count cycles later.
- Three btn_up presses during NS_GREEN -> green_len = 23; current remain unaffected; EW_GREEN loads 23.
- 20 btn_dn presses -> green_len saturates at 5; btn_up and btn_dn pressed in the same cycle -> no change.
- Force phase = 7 via bench deposit -> next cycle phase = 0 and remain = green_len; rst_n pulsed mid-yellow -> phase 0, remain 20, cnt 2/0.
